// File: rtl/spi_slave.sv
// SPI slave (sample on sclk fall, LSB first): pins oversampled in mclk; pin edges act SYNC_STAGES+1 mclk edges later.
// Backpressure: unread rx byte drops new bytes (rx_overrun); empty tx holding register sends 0x00 (tx_underrun).
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                   state, state_nxt;
  logic [SYNC_STAGES-1:0]   sclk_sync, cs_sync, mosi_sync, prime;
  logic                     sclk_d, cs_d, armed;
  logic                     sclk_s, cs_s, mosi_s;
  logic                     sclk_fall, cs_fall, cs_rise;
  logic                     enter, abort, fall_act, byte_done, tx_load;
  logic [DATA_W-1:0]        rx_shift, tx_shift, tx_hold, rx_next;
  logic                     tx_full;
  logic [CNT_W-1:0]         bit_cnt;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_fall = sclk_d & ~sclk_s;
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;

  // cs synchroniser resets high, so a frame may only start once a real high level has reached cs_s.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      prime     <= '0;
      armed     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      prime     <= {prime[SYNC_STAGES-2:0], 1'b1};
      armed     <= armed | (prime[SYNC_STAGES-1] & cs_s);
      busy      <= armed & ~cs_s;
    end
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall && armed) state_nxt = ACTIVE;
      ACTIVE:  if (cs_rise)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    miso = (state == ACTIVE) ? tx_shift[0] : 1'b0;
  end

  assign enter     = (state == IDLE) && cs_fall && armed;
  assign abort     = (state == ACTIVE) && cs_rise;
  assign fall_act  = (state == ACTIVE) && sclk_fall && !cs_rise;
  assign byte_done = fall_act && (bit_cnt == LAST_BIT);
  assign tx_load   = enter || byte_done;
  assign rx_next   = {mosi_s, rx_shift[DATA_W-1:1]};
  assign tx_ready  = ~tx_full;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_hold     <= '0;
      tx_full     <= 1'b0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      if (abort) begin
        rx_shift <= '0;
        tx_shift <= '0;
        bit_cnt  <= '0;
      end else if (fall_act) begin
        rx_shift <= rx_next;
        tx_shift <= tx_shift >> 1;
        bit_cnt  <= byte_done ? '0 : bit_cnt + 1'b1;
      end
      if (enter) bit_cnt <= '0;
      // A load always sees the holding register as it was before this cycle's write.
      if (tx_load) begin
        if (tx_full) begin
          tx_shift <= tx_hold;
        end else begin
          tx_shift    <= '0;
          tx_underrun <= 1'b1;
        end
      end
      if (tx_valid && !tx_full) begin
        tx_hold <= tx_data;
        tx_full <= 1'b1;
      end else if (tx_load && tx_full) begin
        tx_full <= 1'b0;
      end
      if (byte_done) begin
        if (rx_valid && !rx_ready) begin
          rx_overrun <= 1'b1;
        end else begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
